// File: rtl/rf_ctrl_pkg.sv
// rf_ctrl_pkg: shared register-file controller state encoding, default widths and clog2 helper
package rf_ctrl_pkg;
  typedef enum logic {ST_ARB, ST_CLEAR} state_t;
  localparam int AW_DEF = 2;
  localparam int DW_DEF = 16;
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return (r < 1) ? 1 : r;
  endfunction
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: one-hot grant of the first valid requester after ptr; fixed lowest-index priority when ARB_FIXED_PRIO_EN is defined
module rr_arbiter
  import rf_ctrl_pkg::*;
#(
  parameter int NREQ = 2,
  localparam int SW = clog2(NREQ)
) (
  input  logic [NREQ-1:0] valid,
`ifndef ARB_FIXED_PRIO_EN
  input  logic [SW-1:0]   ptr,
`endif
  output logic [NREQ-1:0] grant
);
`ifdef ARB_FIXED_PRIO_EN
  always_comb begin
    grant = '0;
    for (int i = NREQ - 1; i >= 0; i--)
      if (valid[i]) grant = NREQ'(1) << i;
  end
`else
  // Later iterations overwrite earlier ones, so ptr+1 (k=1) ends up highest priority.
  always_comb begin
    grant = '0;
    for (int k = NREQ; k >= 1; k--)
      if (valid[(int'(ptr) + k) % NREQ]) grant = NREQ'(1) << ((int'(ptr) + k) % NREQ);
  end
`endif
endmodule

// File: rtl/rf_wr_arbiter.sv
// rf_wr_arbiter: register-file write-port arbiter with bulk CLEAR; ARB_FIXED_PRIO_EN selects fixed priority
module rf_wr_arbiter
  import rf_ctrl_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF,
  localparam int SW = clog2(NREQ)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NREQ-1:0]    req_valid,
  input  logic [NREQ*AW-1:0] req_addr,
  input  logic [NREQ*DW-1:0] req_data,
  output logic [NREQ-1:0]    req_ready,
  input  logic               clr_req,
  output logic               clr_busy,
  output logic               w_flag,
  output logic [AW-1:0]      w_add,
  output logic [DW-1:0]      w_data,
  output logic [SW-1:0]      w_src,
  output logic               w_clr
);
  localparam logic [AW:0] NCLR = {1'b1, {AW{1'b0}}};
  state_t state, state_nx;
  logic [AW:0] clr_cnt, clr_addr;
  logic [NREQ-1:0] grant;
  logic [SW-1:0] gidx;
  logic clr_wr, xfer;
`ifdef ARB_FIXED_PRIO_EN
  rr_arbiter #(.NREQ(NREQ)) u_arb (.valid(req_valid), .grant(grant));
`else
  logic [SW-1:0] rr_ptr;
  rr_arbiter #(.NREQ(NREQ)) u_arb (.valid(req_valid), .ptr(rr_ptr), .grant(grant));
`endif
  // Clear has priority: the clr_req cycle itself grants nothing.
  assign req_ready = (reset && state == ST_ARB && !clr_req) ? grant : '0;
  assign xfer = |req_ready;
  assign clr_busy = state == ST_CLEAR;
  always_comb begin
    gidx = '0;
    for (int i = 0; i < NREQ; i++)
      if (grant[i]) gidx = SW'(i);
  end
  // The first clear write is registered on the same edge that enters CLEAR.
  always_comb begin
    clr_wr = (state == ST_ARB) ? clr_req : (clr_cnt != NCLR);
    clr_addr = (state == ST_ARB) ? '0 : clr_cnt;
    state_nx = clr_wr ? ST_CLEAR : ST_ARB;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ST_ARB;
      clr_cnt <= '0;
`ifndef ARB_FIXED_PRIO_EN
      rr_ptr <= SW'(NREQ - 1);
`endif
      w_flag <= 1'b0;
      w_add <= '0;
      w_data <= '0;
      w_src <= '0;
      w_clr <= 1'b0;
    end else begin
      state <= state_nx;
      if (clr_wr) begin
        clr_cnt <= clr_addr + 1'b1;
        w_flag <= 1'b1;
        w_add <= clr_addr[AW-1:0];
        w_data <= '0;
        w_src <= '0;
        w_clr <= 1'b1;
      end else begin
        w_flag <= xfer;
        w_clr <= 1'b0;
        if (xfer) begin
          w_add <= req_addr[int'(gidx)*AW +: AW];
          w_data <= req_data[int'(gidx)*DW +: DW];
          w_src <= gidx;
`ifndef ARB_FIXED_PRIO_EN
          rr_ptr <= gidx;
`endif
        end
      end
    end
  end
endmodule

// File: tb/tb_rf_wr_arbiter.sv
// tb_rf_wr_arbiter: directed self-checking bench for rf_wr_arbiter
module tb_rf_wr_arbiter;
  logic clk, reset, clr_req, clr_busy, w_flag, w_clr;
  logic [1:0] req_valid, req_ready;
  logic [3:0] req_addr;
  logic [31:0] req_data;
  logic [1:0] w_add;
  logic [15:0] w_data;
  logic [0:0] w_src;
  int checks, failures;
  rf_wr_arbiter dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_addr(req_addr),
    .req_data(req_data), .req_ready(req_ready), .clr_req(clr_req),
    .clr_busy(clr_busy), .w_flag(w_flag), .w_add(w_add), .w_data(w_data),
    .w_src(w_src), .w_clr(w_clr)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic apply_reset;
    reset = 1'b0;
    req_valid = '0;
    clr_req = 1'b0;
    tick();
    reset = 1'b1;
    #1;
  endtask
  task automatic test_reset;
    reset = 1'b0;
    clr_req = 1'b0;
    req_valid = 2'b11;
    req_addr = '0;
    req_data = '0;
    #1;
    checks++;
    if (req_ready !== 2'b00) begin failures++; $display("FAIL reset_ready got=%b exp=00", req_ready); end
    checks++;
    if ({w_flag, w_add, w_data, w_src, w_clr, clr_busy} !== '0)
      begin failures++; $display("FAIL reset_outputs got=%b/%h/%h/%b/%b/%b exp=0", w_flag, w_add, w_data, w_src, w_clr, clr_busy); end
    tick();
    reset = 1'b1;
    req_valid = 2'b01;
    req_addr = {2'd0, 2'd1};
    req_data = {16'h0000, 16'hA5A5};
    #1;
    checks++;
    if (req_ready !== 2'b01) begin failures++; $display("FAIL first_ready got=%b exp=01", req_ready); end
    tick();
    req_valid = 2'b00;
    checks++;
    if ({w_flag, w_add, w_data, w_src} !== {1'b1, 2'd1, 16'hA5A5, 1'b0})
      begin failures++; $display("FAIL first_write got=%b/%h/%h/%b exp=1/1/a5a5/0", w_flag, w_add, w_data, w_src); end
  endtask
  task automatic test_round_robin;
    apply_reset();
    req_valid = 2'b11;
    req_addr = {2'd2, 2'd1};
    req_data = {16'h2222, 16'h1111};
    for (int i = 0; i < 6; i++) begin
      #1;
      checks++;
      if (req_ready !== (2'b01 << (i % 2))) begin failures++; $display("FAIL rr_ready[%0d] got=%b exp=%b", i, req_ready, 2'b01 << (i % 2)); end
      tick();
      checks++;
      if ({w_flag, w_src, w_add, w_data} !== ((i % 2 == 0) ? {1'b1, 1'b0, 2'd1, 16'h1111} : {1'b1, 1'b1, 2'd2, 16'h2222}))
        begin failures++; $display("FAIL rr_write[%0d] got=%b/%b/%h/%h", i, w_flag, w_src, w_add, w_data); end
    end
    req_valid = 2'b00;
    tick();
    checks++;
    if (w_flag !== 1'b0) begin failures++; $display("FAIL rr_idle got=%b exp=0", w_flag); end
  endtask
  task automatic test_clear;
    logic [1:0] exp_g;
`ifdef ARB_FIXED_PRIO_EN
    exp_g = 2'b01;
`else
    exp_g = 2'b10;
`endif
    apply_reset();
    req_valid = 2'b01;
    req_addr = {2'd3, 2'd1};
    req_data = {16'h2222, 16'h1111};
    tick();
    req_valid = 2'b11;
    clr_req = 1'b1;
    #1;
    checks++;
    if (req_ready !== 2'b00) begin failures++; $display("FAIL clr_req_ready got=%b exp=00", req_ready); end
    tick();
    clr_req = 1'b0;
    for (int a = 0; a < 4; a++) begin
      #1;
      checks++;
      if ({w_flag, w_add, w_data, w_clr, clr_busy, req_ready} !== {1'b1, 2'(a), 16'h0, 1'b1, 1'b1, 2'b00})
        begin failures++; $display("FAIL clear_write[%0d] got=%b/%h/%h/%b/%b/%b", a, w_flag, w_add, w_data, w_clr, clr_busy, req_ready); end
      tick();
    end
    checks++;
    if ({w_flag, w_clr, clr_busy, req_ready} !== {1'b0, 1'b0, 1'b0, exp_g})
      begin failures++; $display("FAIL clear_done got=%b/%b/%b/%b exp=0/0/0/%b", w_flag, w_clr, clr_busy, req_ready, exp_g); end
    tick();
    req_valid = 2'b00;
    checks++;
    if ({w_flag, w_clr, w_src} !== {1'b1, 1'b0, exp_g[1]})
      begin failures++; $display("FAIL clear_resume got=%b/%b/%b exp=1/0/%b", w_flag, w_clr, w_src, exp_g[1]); end
  endtask
  task automatic test_reset_abort;
    apply_reset();
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    tick();
    checks++;
    if ({w_flag, w_add, w_clr} !== {1'b1, 2'd1, 1'b1}) begin failures++; $display("FAIL abort_pre got=%b/%h/%b exp=1/1/1", w_flag, w_add, w_clr); end
    reset = 1'b0;
    #1;
    checks++;
    if ({w_flag, w_add, w_clr, clr_busy} !== '0) begin failures++; $display("FAIL abort_async got=%b/%h/%b/%b exp=0", w_flag, w_add, w_clr, clr_busy); end
    tick();
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if ({w_flag, w_clr, clr_busy} !== 3'b000) begin failures++; $display("FAIL abort_after[%0d] got=%b/%b/%b exp=000", i, w_flag, w_clr, clr_busy); end
    end
  endtask
  task automatic test_fixed_prio;
    apply_reset();
    req_valid = 2'b11;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++;
      if (req_ready !== 2'b01) begin failures++; $display("FAIL fixed_ready[%0d] got=%b exp=01", i, req_ready); end
      tick();
    end
    req_valid = 2'b00;
  endtask
  task automatic test_back_to_back;
    apply_reset();
    req_valid = 2'b10;
    for (int k = 0; k < 3; k++) begin
      req_addr[3:2] = (k == 0) ? 2'd3 : (k == 1) ? 2'd2 : 2'd0;
      req_data[31:16] = 16'(k + 1);
      #1;
      checks++;
      if (req_ready !== 2'b10) begin failures++; $display("FAIL b2b_ready[%0d] got=%b exp=10", k, req_ready); end
      tick();
      checks++;
      if ({w_flag, w_src, w_add, w_data} !== {1'b1, 1'b1, (k == 0) ? 2'd3 : (k == 1) ? 2'd2 : 2'd0, 16'(k + 1)})
        begin failures++; $display("FAIL b2b_write[%0d] got=%b/%b/%h/%h", k, w_flag, w_src, w_add, w_data); end
    end
    req_valid = 2'b00;
    tick();
    checks++;
    if (w_flag !== 1'b0) begin failures++; $display("FAIL b2b_idle got=%b exp=0", w_flag); end
  endtask
  initial begin
    checks = 0;
    failures = 0;
    test_reset();
`ifdef ARB_FIXED_PRIO_EN
    test_fixed_prio();
`else
    test_round_robin();
`endif
    test_clear();
    test_reset_abort();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
